// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between EX (port 0) and an
// auxiliary requester (port 1); two-stage issue/result pipeline.
module alu_arbiter #(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [DW-1:0]  req0_da,
    input  logic [DW-1:0]  req0_db,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [DW-1:0]  req1_da,
    input  logic [DW-1:0]  req1_db,
    input  logic [OPW-1:0] req1_op,
    output logic [DW-1:0]  alu_da,
    output logic [DW-1:0]  alu_db,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_dc,
    input  logic           alu_zero,
    input  logic           alu_ovf,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [DW-1:0]  rsp_dc,
    output logic           rsp_zero,
    output logic           rsp_ovf,
    output logic           rsp_illegal
);

    logic           last_grant;
    logic           i_valid;
    logic           i_id;
    logic [DW-1:0]  i_da;
    logic [DW-1:0]  i_db;
    logic [OPW-1:0] i_op;
    logic           r_valid;
    logic           r_id;
    logic [DW-1:0]  r_dc;
    logic           r_zero;
    logic           r_ovf;
    logic           r_illegal;

    logic r_adv;
    logic i_adv;
    logic acc0;
    logic acc1;
    logic op_legal;

    assign r_adv = !r_valid || rsp_ready;
    assign i_adv = !i_valid || r_adv;

    // Port 0 yields only when port 1 is also asking and it is port 1's turn.
    assign req0_ready = rst_n && i_adv
                     && (!req1_valid || last_grant);
    assign req1_ready = rst_n && i_adv
                     && (!req0_valid || !last_grant);

    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;

    always_comb begin
        op_legal = 1'b0;
        case (i_op)
            4'b0000, 4'b1000, 4'b0001, 4'b0010,
            4'b0011, 4'b0100, 4'b0101, 4'b1101,
            4'b0110, 4'b0111: op_legal = 1'b1;
            default:          op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            i_valid    <= 1'b0;
            i_id       <= 1'b0;
            i_da       <= '0;
            i_db       <= '0;
            i_op       <= '0;
        end else if (i_adv) begin
            i_valid <= acc0 || acc1;
            if (acc0 || acc1) begin
                last_grant <= acc1;
                i_id       <= acc1;
                i_da       <= acc1 ? req1_da : req0_da;
                i_db       <= acc1 ? req1_db : req0_db;
                i_op       <= acc1 ? req1_op : req0_op;
            end
        end
    end

    // Result payload is only refreshed by a real operation so idle cycles
    // leave the response bus quiet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_id      <= 1'b0;
            r_dc      <= '0;
            r_zero    <= 1'b0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (r_adv) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_id      <= i_id;
                r_dc      <= op_legal ? alu_dc : '0;
                r_zero    <= op_legal && alu_zero;
                r_ovf     <= op_legal && alu_ovf;
                r_illegal <= !op_legal;
            end
        end
    end

    assign alu_da      = i_da;
    assign alu_db      = i_db;
    assign alu_op      = i_op;
    assign rsp_valid   = r_valid;
    assign rsp_id      = r_id;
    assign rsp_dc      = r_dc;
    assign rsp_zero    = r_zero;
    assign rsp_ovf     = r_ovf;
    assign rsp_illegal = r_illegal;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a queue-based
// model of a two-deep, round-robin, in-order ALU service.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [31:0] req0_da = '0;
    logic [31:0] req0_db = '0;
    logic [3:0]  req0_op = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [31:0] req1_da = '0;
    logic [31:0] req1_db = '0;
    logic [3:0]  req1_op = '0;
    logic [31:0] alu_da;
    logic [31:0] alu_db;
    logic [3:0]  alu_op;
    logic [31:0] alu_dc;
    logic        alu_zero;
    logic        alu_ovf;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [31:0] rsp_dc;
    logic        rsp_zero;
    logic        rsp_ovf;
    logic        rsp_illegal;

    alu_arbiter #(.DW(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_da(req0_da), .req0_db(req0_db), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_da(req1_da), .req1_db(req1_db), .req1_op(req1_op),
        .alu_da(alu_da), .alu_db(alu_db), .alu_op(alu_op),
        .alu_dc(alu_dc), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_dc(rsp_dc), .rsp_zero(rsp_zero),
        .rsp_ovf(rsp_ovf), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] dc;
        logic        z;
        logic        o;
        logic        ill;
        int          t;
    } exp_t;

    exp_t q[$];
    logic gseq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_rsp = 0;
    logic pri = 1'b0;
    logic [31:0] l_dc;
    logic        l_id, l_z, l_o, l_ill;
    logic [3:0]  legal_ops [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010,
                                    4'b0011, 4'b0100, 4'b0101, 4'b1101,
                                    4'b0110, 4'b0111};

    // Reference ALU: the bench plays the role of the shared ALU.
    function automatic logic [33:0] alu_f(logic [31:0] a, logic [31:0] b,
                                          logic [3:0] op);
        logic [31:0] r;
        logic        o;
        o = 1'b0;
        case (op)
            4'b0000: begin
                r = a + b;
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b1000: begin
                r = a - b;
                o = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0001: r = a << b[4:0];
            4'b0010: r = {31'd0, $signed(a) < $signed(b)};
            4'b0011: r = {31'd0, a < b};
            4'b0100: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b1101: r = $signed(a) >>> b[4:0];
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: begin
                r = a + b;
                o = r[0];
            end
        endcase
        return {r, r == 32'd0, o};
    endfunction

    always_comb {alu_dc, alu_zero, alu_ovf} = alu_f(alu_da, alu_db, alu_op);

    function automatic exp_t predict(logic id, logic [31:0] a,
                                     logic [31:0] b, logic [3:0] op, int t);
        exp_t e;
        logic [33:0] f;
        e.id = id;
        e.t  = t;
        if (op inside {legal_ops}) begin
            f     = alu_f(a, b, op);
            e.dc  = f[33:2];
            e.z   = f[1];
            e.o   = f[0];
            e.ill = 1'b0;
        end else begin
            e.dc  = '0;
            e.z   = 1'b0;
            e.o   = 1'b0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model, clock the DUT.
    task automatic tick();
        logic cap, er0, er1, a0, a1, ev;
        @(negedge clk);
        if (!rst_n) begin
            chk("rdy0_in_rst", req0_ready, 0);
            chk("rdy1_in_rst", req1_ready, 0);
            @(posedge clk);
            #1;
            cyc++;
            q.delete();
            pri = 1'b0;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            chk("rst_valid", rsp_valid, 0);
            chk("rst_id", rsp_id, 0);
            chk("rst_dc", rsp_dc, 0);
            chk("rst_flags", {rsp_zero, rsp_ovf, rsp_illegal}, 0);
            chk("rst_alu_da", alu_da, 0);
            chk("rst_alu_db", alu_db, 0);
            chk("rst_alu_op", alu_op, 0);
            return;
        end
        cap = (q.size() < 2) || rsp_ready;
        er0 = cap && (!req1_valid || pri == 1'b0);
        er1 = cap && (!req0_valid || pri == 1'b1);
        chk("req0_ready", req0_ready, er0);
        chk("req1_ready", req1_ready, er1);
        ev = (q.size() > 0) && (q[0].t + 2 <= cyc);
        chk("rsp_valid", rsp_valid, ev);
        if (ev && rsp_valid) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_dc", rsp_dc, q[0].dc);
            chk("rsp_zero", rsp_zero, q[0].z);
            chk("rsp_ovf", rsp_ovf, q[0].o);
            chk("rsp_illegal", rsp_illegal, q[0].ill);
            if (rsp_ready) begin
                void'(q.pop_front());
                n_rsp++;
                l_id  = rsp_id;
                l_dc  = rsp_dc;
                l_z   = rsp_zero;
                l_o   = rsp_ovf;
                l_ill = rsp_illegal;
            end
        end
        a0 = req0_valid && er0;
        a1 = req1_valid && er1;
        if (a0) q.push_back(predict(0, req0_da, req0_db, req0_op, cyc));
        if (a1) q.push_back(predict(1, req1_da, req1_db, req1_op, cyc));
        if (a0) gseq.push_back(1'b0);
        if (a1) gseq.push_back(1'b1);
        if (a0 || a1) begin
            pri = a0;
            n_acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (a0) req0_valid = 1'b0;
        if (a1) req1_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (q.size() == 0 && !req0_valid && !req1_valid) break;
            tick();
        end
        chk("drain_empty", q.size() + req0_valid + req1_valid, 0);
    endtask

    task automatic put(int p, logic [3:0] op, logic [31:0] a,
                       logic [31:0] b);
        if (p == 0) begin
            req0_valid = 1'b1;
            req0_op = op;
            req0_da = a;
            req0_db = b;
        end else begin
            req1_valid = 1'b1;
            req1_op = op;
            req1_da = a;
            req1_db = b;
        end
    endtask

    task automatic run_one(int p, logic [3:0] op, logic [31:0] a,
                           logic [31:0] b, logic [31:0] e_dc,
                           logic e_z, logic e_o, logic e_i);
        put(p, op, a, b);
        drain();
        chk("dir_id", l_id, p[0]);
        chk("dir_dc", l_dc, e_dc);
        chk("dir_zero", l_z, e_z);
        chk("dir_ovf", l_o, e_o);
        chk("dir_illegal", l_ill, e_i);
    endtask

    function automatic logic [3:0] rand_op();
        if ($urandom_range(0, 7) == 0) return 4'($urandom);
        return legal_ops[$urandom_range(0, 9)];
    endfunction

    initial begin
        tick();
        tick();
        rst_n = 1'b1;

        // both ports streaming: strict alternation starting at port 0
        gseq.delete();
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (!req0_valid) put(0, 4'b0000, 32'($urandom), 32'(k));
            if (!req1_valid) put(1, 4'b0100, 32'($urandom), 32'(k));
            tick();
        end
        drain();
        for (int k = 0; k < 6; k++)
            chk("grant_seq", gseq[k], k % 2);

        run_one(0, 4'b0000, 32'h00EEE001, 32'h00111F10,
                32'h00FFFF11, 0, 0, 0);
        run_one(1, 4'b1000, 32'h00EEE001, 32'h00EEE001,
                32'h0, 1, 0, 0);
        run_one(0, 4'b0000, 32'h7FFFFFFF, 32'h00000001,
                32'h80000000, 0, 1, 0);
        run_one(0, 4'b1111, 32'h12345678, 32'h0000FFFF,
                32'h0, 0, 0, 1);
        run_one(0, 4'b1101, 32'h80EEE001, 32'h00000010,
                32'hFFFF80EE, 0, 0, 0);

        // backpressure with both ports streaming
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rsp_ready = !(k >= 2 && k < 6);
            if (!req0_valid) put(0, rand_op(), $urandom, $urandom);
            if (!req1_valid) put(1, rand_op(), $urandom, $urandom);
            tick();
        end
        drain();

        for (int k = 0; k < 400; k++) begin
            if (!req0_valid && $urandom_range(0, 2) != 0)
                put(0, rand_op(), $urandom, $urandom);
            if (!req1_valid && $urandom_range(0, 2) != 0)
                put(1, rand_op(), $urandom, $urandom);
            rsp_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        drain();
        chk("acc_eq_rsp", n_acc, n_rsp);

        // reset with two operations in flight
        rsp_ready = 1'b0;
        put(0, 4'b0000, 32'd1, 32'd2);
        tick();
        put(1, 4'b0110, 32'd4, 32'd8);
        tick();
        chk("two_in_flight", q.size(), 2);
        put(0, 4'b0000, 32'd5, 32'd5);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        gseq.delete();
        put(0, 4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0);
        put(1, 4'b0011, 32'd3, 32'd9);
        drain();
        chk("post_rst_first", gseq[0], 0);
        chk("post_rst_count", gseq.size(), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU of the pipeline CPU between two requesters: port 0 is the EX stage, port 1 is an auxiliary unit such as address generation or a multi-cycle helper.
- Arbitrates round-robin and registers the winning operation.
- Drives the ALU from that register, captures ALU_DC/ALU_ZERO/ALU_OverFlow, and returns a tagged response under a valid/ready handshake.
- Two-stage pipeline: issue (I) and result (R); throughput of one operation per cycle.

Parameters:
- DW, 32, operand/result width.
- OPW, 4, ALUCLT width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_da, req0_db / req1_da, req1_db  in  DW  operands A and B.
- req0_op / req1_op  in  OPW  ALUCLT code.
- alu_da, alu_db  out  DW  to ALU_DA/ALU_DB.
- alu_op  out  OPW  to ALUCLT.
- alu_dc  in  DW  from ALU_DC.
- alu_zero  in  1  from ALU_ZERO.
- alu_ovf  in  1  from ALU_OverFlow.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester index of the response.
- rsp_dc  out  DW  result.
- rsp_zero  out  1  zero flag.
- rsp_ovf  out  1  overflow flag.
- rsp_illegal  out  1  op code was not a legal ALU op.

Behaviour:
- Reset: rst_n=0 sampled at an edge clears i_valid, r_valid and last_grant. last_grant resets to 1, so port 0 wins first.
  - While rst_n=0: req*_ready=0.
  - After that edge: rsp_valid=0, rsp_id=0, rsp_dc=0, rsp_zero=0, rsp_ovf=0, rsp_illegal=0, alu_da=0, alu_db=0, alu_op=0.
  - Reset mid-operation discards in-flight operations; no response is ever produced for them.
- Stall logic:
  - r_adv = !r_valid | rsp_ready.
  - i_adv = !i_valid | r_adv.
  - req*_ready is combinational from the grant and i_adv only. It never depends on req*_valid of the same port.
- Arbitration, evaluated when i_adv=1:
  - Only one port valid: grant it.
  - Both valid: grant the port != last_grant.
  - last_grant updates only on an accepted grant. An idle cycle keeps the pointer.
  - The loser's ready=0, so it holds its request.
  - Requesters must keep valid and payload stable until accepted.
- Stage I: on accept, the I register loads {id, da, db, op} and i_valid=1.
  - If i_adv=1 and nothing is granted, i_valid goes to 0.
  - If i_adv=0, the I register holds.
  - alu_da/alu_db/alu_op are driven directly from the I register. They are held stable while stalled.
  - When i_valid=0, the I register keeps its last value (no toggling).
- Stage R: when r_adv=1, R loads {i_id, alu_dc, alu_zero, alu_ovf, illegal} and r_valid=i_valid.
  - When r_adv=0, all rsp_* outputs hold.
- Latency: a request handshake in cycle t gives rsp_valid=1 in cycle t+2 with no backpressure. Back-to-back operations produce responses on consecutive cycles.
- Illegal ops:
  - Legal op codes: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.
  - Any other code gives rsp_illegal=1, rsp_dc=0, rsp_zero=0, rsp_ovf=0.
  - The op is still issued to the ALU unchanged.
- Backpressure: rsp_valid=1 with rsp_ready=0 stalls R, then I; both ready outputs drop once I is occupied.
  - At most 2 operations are in flight.
  - Nothing is dropped or reordered.
- Simultaneous events:
  - Response consumed and new request accepted in the same cycle is allowed, with full throughput.
  - A request arriving in the same cycle rsp_ready rises is accepted if i_adv=1.
- Ordering: responses are returned strictly in grant order.

Test Plan:
1. req0 add, da=0x00EEE001, db=0x00111F10 -> at t+2: rsp_valid=1, rsp_id=0, rsp_dc=0x00FFFF11, rsp_zero=0, rsp_ovf=0.
2. req1 sub, da=db=0x00EEE001 -> rsp_id=1, rsp_dc=0, rsp_zero=1. Then req0 add 0x7FFFFFFF+0x00000001 -> rsp_dc=0x80000000, rsp_ovf=1.
3. Both ports valid continuously for 6 cycles, rsp_ready=1 -> grant order 0,1,0,1,0,1; rsp_id sequence matches; one response per cycle.
4. rsp_ready=0 for 4 cycles with both ports streaming -> rsp_* frozen; both readys drop after 2 in flight. Release -> responses resume in order with none lost or duplicated.
5. req0_op=4'b1111, da=0x12345678 -> rsp_illegal=1, rsp_dc=0. Then a legal sra, da=0x80EEE001, db=0x10 -> rsp_dc=0xFFFF80EE, rsp_illegal=0.
6. rst_n=0 for 1 cycle with 2 operations in flight -> next cycle rsp_valid=0 and the ALU drive outputs are 0. No stale response appears. The first grant after reset goes to port 0 when both ports are valid.
